// File: rtl/uart_pkg.sv
// Shared widths, types and the lane-to-word packing helper for the UART word packer.
package uart_pkg;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [WORD_W-1:0] word_t;

    // partial holds lanes 0..2 at [7:0], [15:8], [23:16]; last is lane 3.
    // Lane 0 is the first byte received.
    function automatic word_t pack_word(input byte_t last, input logic [23:0] partial, input bit le);
        word_t w;
        if (le) w = {last, partial};
        else    w = {partial[7:0], partial[15:8], partial[23:16], last};
        return w;
    endfunction
endpackage

// File: rtl/word_fifo.sv
// Synchronous first-word-fall-through FIFO with a register-array store and a flush input.
module word_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  word_t                    push_data_i,
    input  logic                     pop_i,
    output word_t                    head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    word_t          mem_q [DEPTH];
    logic [AW:0]    wptr_q, wptr_d;
    logic [AW:0]    rptr_q, rptr_d;
    logic           do_push, do_pop;

    assign count_o = wptr_q - rptr_q;
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (count_o == '0);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
        end
    end
endmodule

// File: rtl/uart_rx_word_packer.sv
// Packs UART receiver bytes into 32-bit words and queues them in an FWFT FIFO,
// with sticky flags for framing errors and dropped words.
module uart_rx_word_packer
    import uart_pkg::*;
#(
    parameter int DEPTH         = 16,
    parameter bit LITTLE_ENDIAN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BYTE_W-1:0]        rx_data,
    input  logic                     rx_valid,
    input  logic                     rx_ferr,
    input  logic                     flush,
    input  logic                     clr_err,
    output logic [WORD_W-1:0]        word_data,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     ferr_seen
);
    logic [1:0]  idx_q, idx_d;
    logic [23:0] partial_q, partial_d;
    logic        ovf_q, ovf_d;
    logic        ferr_q, ferr_d;

    logic        byte_ok, push, pop, full, empty;
    word_t       push_word;

    assign byte_ok   = rx_valid & ~rx_ferr & ~flush;
    assign push      = byte_ok & (idx_q == 2'd3);
    assign pop       = word_ready & ~empty;
    assign push_word = pack_word(rx_data, partial_q, LITTLE_ENDIAN);

    always_comb begin
        idx_d     = idx_q;
        partial_d = partial_q;
        if (flush || (rx_valid && rx_ferr)) begin
            idx_d = 2'd0;
        end else if (byte_ok) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0:    partial_d[7:0]   = rx_data;
                2'd1:    partial_d[15:8]  = rx_data;
                2'd2:    partial_d[23:16] = rx_data;
                default: partial_d        = partial_q;
            endcase
        end
    end

    // A set event outranks clr_err in the same cycle.
    always_comb begin
        ovf_d  = clr_err ? 1'b0 : ovf_q;
        ferr_d = clr_err ? 1'b0 : ferr_q;
        if (push && full && !pop)  ovf_d  = 1'b1;
        if (rx_valid && rx_ferr)   ferr_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= '0;
            partial_q <= '0;
            ovf_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            partial_q <= partial_d;
            ovf_q     <= ovf_d;
            ferr_q    <= ferr_d;
        end
    end

    word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (push_word),
        .pop_i       (word_ready),
        .head_o      (word_data),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign word_valid = ~empty;
    assign overflow   = ovf_q;
    assign ferr_seen  = ferr_q;
endmodule

// File: tb/tb_uart_rx_word_packer.sv
// Directed bench for uart_rx_word_packer; a big-endian twin shares the same stimulus.
module tb_uart_rx_word_packer;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 0;
    logic          rst = 1;
    logic [7:0]    rx_data = 0;
    logic          rx_valid = 0, rx_ferr = 0, flush = 0, clr_err = 0, word_ready = 0;

    logic [31:0]   word_data, word_data_be;
    logic          word_valid, word_valid_be;
    logic [CW-1:0] count, count_be;
    logic          overflow, overflow_be, ferr_seen, ferr_seen_be;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx_word_packer #(.DEPTH(DEPTH), .LITTLE_ENDIAN(1'b1)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
        .flush(flush), .clr_err(clr_err), .word_data(word_data), .word_valid(word_valid),
        .word_ready(word_ready), .count(count), .overflow(overflow), .ferr_seen(ferr_seen)
    );

    uart_rx_word_packer #(.DEPTH(DEPTH), .LITTLE_ENDIAN(1'b0)) dut_be (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
        .flush(flush), .clr_err(clr_err), .word_data(word_data_be), .word_valid(word_valid_be),
        .word_ready(word_ready), .count(count_be), .overflow(overflow_be), .ferr_seen(ferr_seen_be)
    );

    task automatic send_byte(input logic [7:0] b, input logic ferr);
        @(negedge clk);
        rx_data = b; rx_valid = 1; rx_ferr = ferr;
        @(posedge clk); #1;
        rx_valid = 0; rx_ferr = 0;
    endtask

    // Bytes of test word k: k, A0, B0, C0 -> LE word 32'hC0B0A0kk.
    task automatic send_word(input logic [7:0] k);
        send_byte(k, 0); send_byte(8'hA0, 0); send_byte(8'hB0, 0); send_byte(8'hC0, 0);
    endtask

    task automatic pulse_flush_clr();
        @(negedge clk);
        flush = 1; clr_err = 1;
        @(posedge clk); #1;
        flush = 0; clr_err = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (word_valid !== 0 || count !== 0 || overflow !== 0 || ferr_seen !== 0 || word_data !== 0) begin
            failures++;
            $display("FAIL reset: valid=%b count=%0d ovf=%b ferr=%b data=%h, want all 0",
                     word_valid, count, overflow, ferr_seen, word_data);
        end
        rst = 0;
    endtask

    task automatic test_le_basic();
        send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
        @(negedge clk);
        checks++;
        if (word_valid !== 0) begin failures++; $display("FAIL le_partial_valid: got %b want 0", word_valid); end
        send_byte(8'h44, 0);
        @(negedge clk);
        checks++;
        if (word_valid !== 1 || count !== 1) begin
            failures++; $display("FAIL le_valid_count: valid=%b count=%0d want 1/1", word_valid, count);
        end
        checks++;
        if (word_data !== 32'h44332211) begin
            failures++; $display("FAIL le_data: got %h want 44332211", word_data);
        end
        pulse_flush_clr();
    endtask

    task automatic test_big_endian();
        send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0); send_byte(8'hEF, 0);
        @(negedge clk);
        checks++;
        if (word_valid_be !== 1 || word_data_be !== 32'hDEADBEEF) begin
            failures++; $display("FAIL be_data: valid=%b data=%h want 1/DEADBEEF", word_valid_be, word_data_be);
        end
        pulse_flush_clr();
    endtask

    task automatic test_ferr();
        send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'h99, 1);
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
        @(negedge clk);
        checks++;
        if (count !== 1 || word_data !== 32'h04030201) begin
            failures++; $display("FAIL ferr_word: count=%0d data=%h want 1/04030201", count, word_data);
        end
        checks++;
        if (ferr_seen !== 1) begin failures++; $display("FAIL ferr_sticky: got %b want 1", ferr_seen); end
        clr_err = 1;
        @(posedge clk); #1; clr_err = 0;
        @(negedge clk);
        checks++;
        if (ferr_seen !== 0) begin failures++; $display("FAIL ferr_clear: got %b want 0", ferr_seen); end
        // Set in the same cycle as clear: set wins.
        @(negedge clk);
        clr_err = 1; rx_valid = 1; rx_ferr = 1; rx_data = 8'h55;
        @(posedge clk); #1;
        clr_err = 0; rx_valid = 0; rx_ferr = 0;
        @(negedge clk);
        checks++;
        if (ferr_seen !== 1) begin failures++; $display("FAIL ferr_set_vs_clr: got %b want 1", ferr_seen); end
        pulse_flush_clr();
    endtask

    task automatic test_overflow_wrap();
        for (int k = 0; k < DEPTH; k++) send_word(8'(k));
        @(negedge clk);
        checks++;
        if (count !== CW'(DEPTH) || overflow !== 0) begin
            failures++; $display("FAIL fill: count=%0d ovf=%b want %0d/0", count, overflow, DEPTH);
        end
        send_word(8'h10);
        @(negedge clk);
        checks++;
        if (count !== CW'(DEPTH) || overflow !== 1 || word_data !== 32'hC0B0A000) begin
            failures++; $display("FAIL overflow: count=%0d ovf=%b head=%h want %0d/1/C0B0A000",
                                 count, overflow, word_data, DEPTH);
        end
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            checks++;
            if (word_valid !== 1 || word_data !== {24'hC0B0A0, 8'(k)}) begin
                failures++; $display("FAIL drain[%0d]: valid=%b data=%h want 1/%h",
                                     k, word_valid, word_data, {24'hC0B0A0, 8'(k)});
            end
            word_ready = 1;
            @(posedge clk); #1; word_ready = 0;
        end
        @(negedge clk);
        checks++;
        if (word_valid !== 0 || count !== 0) begin
            failures++; $display("FAIL drained_empty: valid=%b count=%0d want 0/0", word_valid, count);
        end
        // Pointers have wrapped; two more words must come out in order.
        send_word(8'h20); send_word(8'h21);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (word_valid !== 1 || word_data !== {24'hC0B0A0, 8'(8'h20 + k)}) begin
                failures++; $display("FAIL wrap[%0d]: valid=%b data=%h want 1/%h",
                                     k, word_valid, word_data, {24'hC0B0A0, 8'(8'h20 + k)});
            end
            word_ready = 1;
            @(posedge clk); #1; word_ready = 0;
        end
        pulse_flush_clr();
    endtask

    task automatic test_full_push_pop();
        for (int k = 0; k < DEPTH; k++) send_word(8'(8'h30 + k));
        send_byte(8'h40, 0); send_byte(8'hA0, 0); send_byte(8'hB0, 0);
        @(negedge clk);
        rx_data = 8'hC0; rx_valid = 1; word_ready = 1;
        @(posedge clk); #1;
        rx_valid = 0; word_ready = 0;
        @(negedge clk);
        checks++;
        if (count !== CW'(DEPTH) || overflow !== 0 || word_data !== 32'hC0B0A031) begin
            failures++; $display("FAIL full_push_pop: count=%0d ovf=%b head=%h want %0d/0/C0B0A031",
                                 count, overflow, word_data, DEPTH);
        end
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            checks++;
            if (word_valid !== 1 || word_data !== {24'hC0B0A0, 8'(8'h30 + k)}) begin
                failures++; $display("FAIL fpp_drain[%0d]: valid=%b data=%h want 1/%h",
                                     k, word_valid, word_data, {24'hC0B0A0, 8'(8'h30 + k)});
            end
            word_ready = 1;
            @(posedge clk); #1; word_ready = 0;
        end
        pulse_flush_clr();
    endtask

    task automatic test_flush_and_async_reset();
        send_word(8'h01); send_word(8'h02); send_word(8'h03);
        send_byte(8'h77, 0); send_byte(8'h88, 0);
        @(negedge clk);
        flush = 1;
        @(posedge clk); #1; flush = 0;
        @(negedge clk);
        checks++;
        if (count !== 0 || word_valid !== 0) begin
            failures++; $display("FAIL flush: count=%0d valid=%b want 0/0", count, word_valid);
        end
        send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
        @(negedge clk);
        checks++;
        if (count !== 1 || word_data !== 32'h04030201) begin
            failures++; $display("FAIL post_flush_word: count=%0d data=%h want 1/04030201", count, word_data);
        end
        send_byte(8'h66, 1);
        send_byte(8'h05, 0); send_byte(8'h06, 0);
        @(negedge clk); #2;
        rst = 1;
        #1;
        checks++;
        if (word_valid !== 0 || count !== 0 || overflow !== 0 || ferr_seen !== 0 || word_data !== 0) begin
            failures++; $display("FAIL async_rst: valid=%b count=%0d ovf=%b ferr=%b data=%h want all 0",
                                 word_valid, count, overflow, ferr_seen, word_data);
        end
        @(negedge clk); rst = 0;
        send_byte(8'hA1, 0); send_byte(8'hB2, 0); send_byte(8'hC3, 0); send_byte(8'hD4, 0);
        @(negedge clk);
        checks++;
        if (count !== 1 || word_data !== 32'hD4C3B2A1) begin
            failures++; $display("FAIL post_rst_word: count=%0d data=%h want 1/D4C3B2A1", count, word_data);
        end
    endtask

    initial begin
        test_reset();
        test_le_basic();
        test_big_endian();
        test_ferr();
        test_overflow_wrap();
        test_full_push_pop();
        test_flush_and_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
